xor_issue_ctrl: RTL and testbench
=================================

// Module: xor_issue_ctrl
// PURPOSE
// - Issue/collect stage wrapped around the 16-bit XOR array (xor16b): accepts tagged operand pairs
//   on a valid/ready port, registers them onto the array inputs and tracks each op through the
//   array's fixed latency.
// - Captures each Cout word into a result FIFO and returns it in order with its tag.
// - Credit-based issue throttling means the FIFO never overflows.
// - Sits between the ALU operand dispatch and the ALU result mux.
// PARAMETERS
// - WIDTH  16  operand/result width; must match the xor16b instance.
// - LAT    2   cycles from xa/xb update (edge t) to a valid xcout sample (edge t+LAT); LAT >= 1.
// - DEPTH  4   result FIFO entries, which is also the total credit count; power of 2, >= 2.
// - TAGW   4   tag width carried alongside each op.
// PORTS
// - clkpos1    in   1       single clock; all state updates on its rising edge.
// - rstn       in   1       reset, synchronous, active-low.
// - in_valid   in   1       operand pair offered.
// - in_ready   out  1       block can accept an op this cycle.
// - in_a       in   WIDTH   operand A.
// - in_b       in   WIDTH   operand B.
// - in_tag     in   TAGW    op tag; returned unchanged with the result.
// - xa         out  WIDTH   registered A to the xor16b A input.
// - xb         out  WIDTH   registered B to the xor16b B input.
// - xcout      in   WIDTH   xor16b Cout.
// - out_valid  out  1       result available.
// - out_ready  in   1       consumer accepts the result.
// - out_data   out  WIDTH   result word (FIFO head).
// - out_tag    out  TAGW    tag of the head result.
// - inflight   out  $clog2(DEPTH+1)  ops issued but not yet pushed into the FIFO.
// BEHAVIOUR
// - Reset (rstn=0 at an edge): xa=xb=0, vpipe=0, FIFO empty, credits=DEPTH, out_valid=0.
//   - in_ready is forced to 0 while rstn=0.
//   - Mid-operation reset silently drops in-flight ops and queued results, with no partial output.
// - in_ready = rstn & (credits != 0). credits is a register; in_ready depends on no input.
// - Issue = in_valid & in_ready.
//   - On issue: xa<=in_a, xb<=in_b, vpipe[0]<=1, tpipe[0]<=in_tag.
//   - Otherwise xa/xb hold their value (no toggling, to save adiabatic switching energy) and vpipe[0]<=0.
// - vpipe/tpipe is a LAT-stage shift register. When vpipe[LAT-1]=1 at an edge, xcout and
//   tpipe[LAT-1] are pushed into the FIFO at that edge.
// - Result latency: an op issued at edge t is pushed at edge t+LAT and can show out_valid in
//   cycle t+LAT, so one op takes LAT+1 cycles from in_valid to out_valid.
// - Pop = out_valid & out_ready. out_data/out_tag come from the FIFO head and stay stable while
//   out_valid=1 and out_ready=0.
// - Credits: issue alone gives -1; pop alone gives +1; issue and pop in the same cycle give no
//   change.
//   - Invariant: credits + inflight + fifo_count == DEPTH (assertion).
// - Back-to-back issue gives 1 op/cycle while credits remain. Throughput is sustained at 1/cycle
//   when out_ready=1 and DEPTH >= LAT+1.
// - FIFO full: a push is impossible by the credit invariant; a push while full is an assertion failure.
// - FIFO empty: out_valid=0; out_data holds its last value and is don't-care.
// - A push and a pop in the same cycle are both honoured, and occupancy is unchanged.
// - Pointers are log2(DEPTH) bits and wrap naturally; full/empty are tracked by a separate
//   count register.
// - Ordering: results leave in strict issue order; tags are never reordered.
// STRUCTURE
// - Package alu_pkg holds:
//   - ALU_W=16, TAG_W=4;
//   - typedef logic [ALU_W-1:0] word_t;
//   - typedef struct packed {word_t data; logic [TAG_W-1:0] tag;} alu_res_t.
// - One sub-module, alu_res_fifo: synchronous FIFO of alu_res_t with DEPTH entries, rstn and
//   push/pop, and full/empty/count outputs.
// - The valid/tag pipe, the xa/xb registers and the credit counter stay in this module.
// - No combinational path from in_valid to in_ready, or from out_ready to in_ready.
// TESTING
// - Single op: A=16'hF0F0, B=16'h0FF0, tag=3.
//   - Expect out_valid in cycle 3 after issue, with out_data=16'hFF00 and out_tag=3.
// - Streaming: 16 ops with out_ready=1, A=i and B=16'hAAAA. Expect 16 results in order with
//   data=i^16'hAAAA and in_ready held at 1 throughout.
// - Backpressure: out_ready=0 and 6 ops offered.
//   - Expect exactly 4 accepts; in_ready=0 after the 4th; credits=0.
//   - Raise out_ready and expect 4 results, then the remaining 2 ops are accepted.
// - Simultaneous: FIFO holding 2 entries, with issue and pop in the same cycle.
//   - Expect credits unchanged, count unchanged after the push lands, and no data loss.
// - Mid-operation reset: assert rstn=0 for 1 cycle with 2 ops in flight and 2 queued.
//   - Expect out_valid=0, inflight=0, credits=4 and xa=xb=0.
//   - Expect no stale result to appear afterwards.
// - xa hold: no issue for 10 cycles. Expect xa/xb unchanged, bit for bit.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU result types: the data word and the tagged result carried from the
// xor16b issue stage to the result mux.
package alu_pkg;
  localparam int ALU_W = 16;
  localparam int TAG_W = 4;

  typedef logic [ALU_W-1:0] word_t;

  typedef struct packed {
    word_t            data;
    logic [TAG_W-1:0] tag;
  } alu_res_t;
endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO of tagged ALU results with a first-word-fall-through head.
// Occupancy is kept in a separate count so that pointers can wrap freely.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  alu_res_t      push_data,
  input  logic          pop,
  output alu_res_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  alu_res_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  assign pop_ok = pop & ~empty;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop_ok) count_d = count_q + CW'(1);
    else if (pop_ok && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn) !(push && full));
endmodule

// File: rtl/xor_issue_ctrl.sv
// Issue/collect stage around the xor16b array: registers operand pairs onto the array, tracks
// each op through the array latency and returns tagged results in order from a credited FIFO.
module xor_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                       clkpos1,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [TAGW-1:0]            in_tag,
  output logic [WIDTH-1:0]           xa,
  output logic [WIDTH-1:0]           xb,
  input  logic [WIDTH-1:0]           xcout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAGW-1:0]            out_tag,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] xa_q, xa_d;
  logic [WIDTH-1:0] xb_q, xb_d;
  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [TAGW-1:0]  tpipe_q [LAT];
  logic [TAGW-1:0]  tpipe_d [LAT];
  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    inflight_cnt;
  logic             issue, pop, push;
  alu_res_t         push_res, head_res;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  // Credits are registered, so in_ready never sees in_valid or out_ready combinationally.
  assign in_ready = rstn & (credits_q != '0);
  assign issue    = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign push     = vpipe_q[LAT-1];

  assign vpipe_d[0] = issue;
  assign tpipe_d[0] = issue ? in_tag : tpipe_q[0];
  for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
    assign vpipe_d[gi] = vpipe_q[gi-1];
    assign tpipe_d[gi] = tpipe_q[gi-1];
  end

  always_comb begin
    xa_d         = xa_q;
    xb_d         = xb_q;
    credits_d    = credits_q;
    inflight_cnt = '0;
    // Operands only move on issue so the array inputs stay quiet between ops.
    if (issue) begin
      xa_d = in_a;
      xb_d = in_b;
    end
    if (issue && !pop) credits_d = credits_q - CW'(1);
    else if (pop && !issue) credits_d = credits_q + CW'(1);
    for (int i = 0; i < LAT; i++) inflight_cnt = inflight_cnt + CW'(vpipe_q[i]);
  end

  always_ff @(posedge clkpos1) begin
    if (!rstn) begin
      xa_q      <= '0;
      xb_q      <= '0;
      vpipe_q   <= '0;
      credits_q <= CW'(DEPTH);
      for (int i = 0; i < LAT; i++) tpipe_q[i] <= '0;
    end else begin
      xa_q      <= xa_d;
      xb_q      <= xb_d;
      vpipe_q   <= vpipe_d;
      credits_q <= credits_d;
      tpipe_q   <= tpipe_d;
    end
  end

  assign push_res = '{data: xcout, tag: tpipe_q[LAT-1]};

  alu_res_fifo #(.DEPTH(DEPTH)) u_res_fifo (
    .clk       (clkpos1),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_res),
    .pop       (pop),
    .head      (head_res),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign xa        = xa_q;
  assign xb        = xb_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = head_res.data;
  assign out_tag   = head_res.tag;
  assign inflight  = inflight_cnt;

  a_credit_balance: assert property (@(posedge clkpos1) disable iff (!rstn)
    (int'(credits_q) + int'(inflight_cnt) + int'(fifo_count)) == DEPTH);
  a_push_room: assert property (@(posedge clkpos1) disable iff (!rstn) !(push && fifo_full));
endmodule

// File: tb/tb_xor_issue_ctrl.sv
// Bench for xor_issue_ctrl: a behavioural xor16b drives xcout, and a queue-based model of
// credits, in-flight ops and queued results supplies every expected value.
module tb_xor_issue_ctrl;
  localparam int WIDTH = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clkpos1 = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [TAGW-1:0]  in_tag = '0;
  logic [WIDTH-1:0] xa, xb, xcout, out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [TAGW-1:0]  out_tag;
  logic [CW-1:0]    inflight;
  logic [WIDTH-1:0] arr_q;

  always #5 clkpos1 = ~clkpos1;

  // xor16b stand-in: one register after the XOR, so Cout is stale at the first edge after
  // xa/xb change and valid at the second.
  always @(posedge clkpos1) arr_q <= xa ^ xb;
  assign xcout = arr_q;

  xor_issue_ctrl #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clkpos1   (clkpos1),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .xa        (xa),
    .xb        (xb),
    .xcout     (xcout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .inflight  (inflight)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [TAGW-1:0]  t;
    int               due;
  } op_t;

  op_t              pend[$];
  op_t              res_m[$];
  int               credits_m = DEPTH;
  int               edge_n = 0;
  logic [WIDTH-1:0] xa_m = '0;
  logic [WIDTH-1:0] xb_m = '0;
  int               checks = 0;
  int               failures = 0;

  // Drive one cycle, advance the model across the rising edge, return at the falling edge.
  task automatic tick(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAGW-1:0] tg, input logic ordy, input logic rn);
    bit  iss, pp;
    op_t op;
    in_valid = v; in_a = a; in_b = b; in_tag = tg; out_ready = ordy; rstn = rn;
    iss = rn && v && (credits_m != 0);
    pp  = rn && ordy && (res_m.size() != 0);
    if (iss) $display("issue a=%h b=%h tag=%0d", a, b, tg);
    if (pp) $display("pop   dut=%h/%0d model=%h/%0d", out_data, out_tag, res_m[0].d, res_m[0].t);
    @(posedge clkpos1);
    edge_n++;
    if (!rn) begin
      pend.delete();
      res_m.delete();
      credits_m = DEPTH;
      xa_m = '0;
      xb_m = '0;
    end else begin
      if (pp) op = res_m.pop_front();
      while (pend.size() != 0 && pend[0].due == edge_n) res_m.push_back(pend.pop_front());
      if (iss) begin
        pend.push_back('{d: a ^ b, t: tg, due: edge_n + LAT});
        xa_m = a;
        xb_m = b;
      end
      credits_m += int'(pp) - int'(iss);
    end
    @(negedge clkpos1);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && (res_m.size() != 0 || pend.size() != 0); c++)
      tick(1'b0, '0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
    tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (inflight !== '0) begin failures++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
    if (xa !== '0) begin failures++; $display("FAIL reset_xa got=%h want=0000", xa); end
    if (xb !== '0) begin failures++; $display("FAIL reset_xb got=%h want=0000", xb); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    tick(1'b1, 16'hF0F0, 16'h0FF0, 4'd3, 1'b0, 1'b1);
    for (int k = 1; k <= LAT + 3; k++) begin
      checks += 2;
      if (out_valid !== (k > LAT)) begin
        failures++; $display("FAIL single_out_valid cycle=%0d got=%b want=%b", k, out_valid, k > LAT);
      end
      if (inflight !== CW'(k <= LAT)) begin
        failures++; $display("FAIL single_inflight cycle=%0d got=%0d want=%0d", k, inflight, k <= LAT);
      end
      if (k > LAT) begin
        checks++;
        if (out_data !== 16'hFF00 || out_tag !== 4'd3) begin
          failures++; $display("FAIL single_result got=%h/%0d want=ff00/3", out_data, out_tag);
        end
      end
      tick(1'b0, WIDTH'($urandom), WIDTH'($urandom), '0, k == LAT + 3, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_after_pop got=%b want=0", out_valid); end
  endtask

  task automatic test_stream();
    int n_out = 0;
    for (int c = 0; c < 16 + LAT + 2; c++) begin
      checks += 2;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cycle=%0d got=%b want=1", c, in_ready); end
      if (out_valid !== (res_m.size() != 0)) begin
        failures++; $display("FAIL stream_out_valid cycle=%0d got=%b want=%b", c, out_valid, res_m.size() != 0);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== (WIDTH'(n_out) ^ 16'hAAAA) || out_tag !== TAGW'(n_out)) begin
          failures++;
          $display("FAIL stream_data idx=%0d got=%h/%0d want=%h/%0d", n_out, out_data, out_tag,
                   WIDTH'(n_out) ^ 16'hAAAA, TAGW'(n_out));
        end
        n_out++;
      end
      tick(c < 16, WIDTH'(c), 16'hAAAA, TAGW'(c), 1'b1, 1'b1);
    end
    checks++;
    if (n_out != 16) begin failures++; $display("FAIL stream_count got=%0d want=16", n_out); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ba [6];
    logic [WIDTH-1:0] bb [6];
    int acc = 0;
    int got = 0;
    int idx;
    for (int i = 0; i < 6; i++) begin ba[i] = WIDTH'($urandom); bb[i] = WIDTH'($urandom); end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (in_ready !== (acc < DEPTH)) begin
        failures++; $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", c, in_ready, acc < DEPTH);
      end
      idx = acc;
      if (in_ready === 1'b1) acc++;
      tick(1'b1, ba[idx], bb[idx], TAGW'(idx), 1'b0, 1'b1);
    end
    checks += 4;
    if (acc != DEPTH) begin failures++; $display("FAIL bp_accepts got=%0d want=%0d", acc, DEPTH); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_credit got=%b want=0", in_ready); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_queued got=%b want=1", out_valid); end
    if (inflight !== '0) begin failures++; $display("FAIL bp_inflight got=%0d want=0", inflight); end
    for (int c = 0; c < 40 && (got < 6 || acc < 6); c++) begin
      checks++;
      if (in_ready !== (credits_m != 0)) begin
        failures++; $display("FAIL bp_release_ready cycle=%0d got=%b want=%b", c, in_ready, credits_m != 0);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 6 || out_data !== (ba[got] ^ bb[got]) || out_tag !== TAGW'(got)) begin
          failures++; $display("FAIL bp_result idx=%0d got=%h/%0d", got, out_data, out_tag);
        end
        got++;
      end
      idx = (acc < 6) ? acc : 0;
      if (in_ready === 1'b1 && acc < 6) acc++;
      tick(idx == acc - 1, ba[idx], bb[idx], TAGW'(idx), 1'b1, 1'b1);
    end
    checks += 2;
    if (got != 6) begin failures++; $display("FAIL bp_results got=%0d want=6", got); end
    if (acc != 6) begin failures++; $display("FAIL bp_total_accepts got=%0d want=6", acc); end
  endtask

  task automatic test_simultaneous();
    logic [16:0]      v_tab, r_tab;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] exp_q[$];
    int acc = 0;
    int got = 0;
    v_tab = 17'b00000000111110011;
    r_tab = 17'b11111111000010000;
    for (int c = 0; c < 17; c++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      checks += 2;
      if (in_ready !== (credits_m != 0)) begin
        failures++; $display("FAIL simul_in_ready cycle=%0d got=%b want=%b", c, in_ready, credits_m != 0);
      end
      if (out_valid !== (res_m.size() != 0)) begin
        failures++; $display("FAIL simul_out_valid cycle=%0d got=%b want=%b", c, out_valid, res_m.size() != 0);
      end
      if (c == 4) begin
        checks++;
        if (out_valid !== 1'b1 || inflight !== '0) begin
          failures++; $display("FAIL simul_two_queued got=%b/%0d want=1/0", out_valid, inflight);
        end
      end
      if (out_valid === 1'b1 && r_tab[c]) begin
        checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          failures++; $display("FAIL simul_data cycle=%0d got=%h", c, out_data);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (v_tab[c] && in_ready === 1'b1) begin
        exp_q.push_back(a ^ b);
        if (c >= 5) acc++;
      end
      tick(v_tab[c], a, b, TAGW'(c), r_tab[c], 1'b1);
    end
    checks += 2;
    if (acc != 2) begin failures++; $display("FAIL simul_credits accepts=%0d want=2", acc); end
    if (got != 5) begin failures++; $display("FAIL simul_drained got=%0d want=5", got); end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 2; i++) tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), TAGW'(i), 1'b0, 1'b1);
    for (int i = 0; i < LAT; i++) tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), TAGW'(i + 2), 1'b0, 1'b1);
    checks++;
    if (inflight !== CW'(2) || out_valid !== 1'b1) begin
      failures++; $display("FAIL mrst_setup inflight=%0d out_valid=%b want=2/1", inflight, out_valid);
    end
    tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%b want=0", out_valid); end
    if (inflight !== '0) begin failures++; $display("FAIL mrst_inflight got=%0d want=0", inflight); end
    if (xa !== '0) begin failures++; $display("FAIL mrst_xa got=%h want=0000", xa); end
    if (xb !== '0) begin failures++; $display("FAIL mrst_xb got=%h want=0000", xb); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale cycle=%0d got=%b want=0", c, out_valid); end
      tick(1'b0, '0, '0, '0, 1'b1, 1'b1);
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      checks++;
      if (in_ready !== (c < DEPTH)) begin
        failures++; $display("FAIL mrst_credits cycle=%0d got=%b want=%b", c, in_ready, c < DEPTH);
      end
      tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), TAGW'(c), 1'b0, 1'b1);
    end
    drain();
  endtask

  task automatic test_xa_hold();
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    tick(1'b1, a, b, 4'd5, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (xa !== a || xb !== b) begin
        failures++; $display("FAIL xa_hold cycle=%0d got=%h/%h want=%h/%h", c, xa, xb, a, b);
      end
      tick(1'b0, WIDTH'($urandom), WIDTH'($urandom), TAGW'($urandom), 1'b1, 1'b1);
    end
    checks++;
    if (xa !== a || xb !== b) begin failures++; $display("FAIL xa_hold_end got=%h/%h want=%h/%h", xa, xb, a, b); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      checks += 4;
      if (in_ready !== (credits_m != 0)) begin
        failures++; $display("FAIL rnd_in_ready cycle=%0d got=%b want=%b", c, in_ready, credits_m != 0);
      end
      if (out_valid !== (res_m.size() != 0)) begin
        failures++; $display("FAIL rnd_out_valid cycle=%0d got=%b want=%b", c, out_valid, res_m.size() != 0);
      end
      if (inflight !== CW'(pend.size())) begin
        failures++; $display("FAIL rnd_inflight cycle=%0d got=%0d want=%0d", c, inflight, pend.size());
      end
      if (xa !== xa_m || xb !== xb_m) begin
        failures++; $display("FAIL rnd_xab cycle=%0d got=%h/%h want=%h/%h", c, xa, xb, xa_m, xb_m);
      end
      if (res_m.size() != 0) begin
        checks++;
        if (out_data !== res_m[0].d || out_tag !== res_m[0].t) begin
          failures++;
          $display("FAIL rnd_result cycle=%0d got=%h/%0d want=%h/%0d", c, out_data, out_tag, res_m[0].d, res_m[0].t);
        end
      end
      tick($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom), TAGW'($urandom),
           $urandom_range(0, 2) != 0, 1'b1);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drained got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_midreset();
    test_xa_hold();
    drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
